// File: rtl/decode_queue.sv
// Purpose : decodes one RV32I instruction per cycle and queues the decoded bundle for execute.
// Latency : an instruction pushed into an empty queue is visible on the head outputs after one edge.
// Backpressure: input_ready_o drops when the queue is full, on stall_request_i or on flush_i.
//
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   input_valid_i/input_ready_o       fetch handshake carrying instr_i and pc_i
//   raddr1_o/rdata1_i, raddr2_o/rdata2_i
//                                     combinational register file read of rs1/rs2
//   stall_request_i                   blocks pushes only
//   flush_i                           empties the queue and refuses the offer
//   output_valid_o/output_ready_i     execute handshake for the head entry
//   pc_o .. illegal_o                 head entry fields (bubble values when empty)
//   count_o                           number of occupied entries
//
// Encodings:
//   alu_op      : the OP/OP_IMM func3 code itself (ALU_ADD = 000).
//   branch_cond : the BRANCH func3 code itself; NO_BRANCH = 010 and
//                 BRANCH_UNCOND = 011, two codes RV32I leaves unused for branches.

module decode_queue #(
    parameter int DEPTH         = 2,
    parameter bit ILLEGAL_CHECK = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       input_valid_i,
    output logic                       input_ready_o,
    input  logic [31:0]                instr_i,
    input  logic [31:0]                pc_i,
    output logic [4:0]                 raddr1_o,
    input  logic [31:0]                rdata1_i,
    output logic [4:0]                 raddr2_o,
    input  logic [31:0]                rdata2_i,
    input  logic                       stall_request_i,
    input  logic                       flush_i,
    output logic                       output_valid_o,
    input  logic                       output_ready_i,
    output logic [31:0]                pc_o,
    output logic [31:0]                alu_operand1_o,
    output logic [31:0]                alu_operand2_o,
    output logic [2:0]                 alu_op_o,
    output logic                       alu_sub_o,
    output logic                       alu_shift_left_o,
    output logic                       alu_signed_shift_o,
    output logic [2:0]                 branch_cond_o,
    output logic [19:0]                branch_offset_o,
    output logic                       reg_write_o,
    output logic [4:0]                 reg_addr_o,
    output logic                       ls_enable_o,
    output logic                       ls_write_o,
    output logic [31:0]                ls_write_data_o,
    output logic [3:0]                 ls_sel_o,
    output logic                       ls_unsigned_load_o,
    output logic                       illegal_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] ALU_ADD       = 3'b000;
    localparam logic [2:0] NO_BRANCH     = 3'b010;
    localparam logic [2:0] BRANCH_UNCOND = 3'b011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_operand1;
        logic [31:0] alu_operand2;
        logic [2:0]  alu_op;
        logic        alu_sub;
        logic        alu_shift_left;
        logic        alu_signed_shift;
        logic [2:0]  branch_cond;
        logic [19:0] branch_offset;
        logic        reg_write;
        logic [4:0]  reg_addr;
        logic        ls_enable;
        logic        ls_write;
        logic [31:0] ls_write_data;
        logic [3:0]  ls_sel;
        logic        ls_unsigned_load;
        logic        illegal;
    } bundle_t;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_shamt;
    logic [31:0] imm;
    bundle_t     dec;

    assign opcode    = instr_i[6:0];
    assign func3     = instr_i[14:12];
    assign raddr1_o  = instr_i[19:15];
    assign raddr2_o  = instr_i[24:20];

    assign imm_i     = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s     = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b     = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
    assign imm_u     = {instr_i[31:12], 12'b0};
    assign imm_j     = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
    assign imm_shamt = {27'b0, instr_i[24:20]};

    always_comb begin
        dec                  = '0;
        imm                  = '0;
        dec.pc               = pc_i;
        dec.alu_op           = ALU_ADD;
        dec.alu_shift_left   = (func3 == F3_SLL);
        dec.alu_signed_shift = instr_i[30];
        dec.branch_cond      = NO_BRANCH;
        dec.reg_write        = 1'b1;
        dec.reg_addr         = instr_i[11:7];
        dec.ls_write_data    = rdata2_i;
        dec.ls_unsigned_load = (func3 == F3_LBU) || (func3 == F3_LHU);
        case (func3[1:0])
            2'b00:   dec.ls_sel = 4'b0001;
            2'b01:   dec.ls_sel = 4'b0011;
            2'b10:   dec.ls_sel = 4'b1111;
            default: dec.ls_sel = 4'b0000;
        endcase

        case (opcode)
            OPC_LUI: begin
                imm              = imm_u;
                dec.alu_operand2 = imm_u;
            end
            OPC_AUIPC: begin
                imm              = imm_u;
                dec.alu_operand1 = pc_i;
                dec.alu_operand2 = imm_u;
            end
            OPC_JAL: begin
                imm              = imm_j;
                dec.alu_operand1 = pc_i;
                dec.alu_operand2 = imm_j;
                dec.branch_cond  = BRANCH_UNCOND;
            end
            OPC_JALR: begin
                imm              = imm_i;
                dec.alu_operand1 = rdata1_i;
                dec.alu_operand2 = imm_i;
                dec.branch_cond  = BRANCH_UNCOND;
            end
            OPC_BRANCH: begin
                imm              = imm_b;
                dec.alu_operand1 = rdata1_i;
                dec.alu_operand2 = rdata2_i;
                dec.branch_cond  = func3;
                dec.reg_write    = 1'b0;
            end
            OPC_LOAD: begin
                imm              = imm_i;
                dec.alu_operand1 = rdata1_i;
                dec.alu_operand2 = imm_i;
                dec.ls_enable    = 1'b1;
            end
            OPC_STORE: begin
                imm              = imm_s;
                dec.alu_operand1 = rdata1_i;
                dec.alu_operand2 = imm_s;
                dec.ls_enable    = 1'b1;
                dec.ls_write     = 1'b1;
                dec.reg_write    = 1'b0;
            end
            OPC_OP_IMM: begin
                // Shift amounts are a plain 5-bit field, not a signed immediate.
                imm              = ((func3 == F3_SLL) || (func3 == F3_SRL)) ? imm_shamt : imm_i;
                dec.alu_operand1 = rdata1_i;
                dec.alu_operand2 = imm;
                dec.alu_op       = func3;
            end
            OPC_OP: begin
                dec.alu_operand1 = rdata1_i;
                dec.alu_operand2 = rdata2_i;
                dec.alu_op       = func3;
                dec.alu_sub      = instr_i[30];
            end
            default: begin
                if (ILLEGAL_CHECK) begin
                    dec.illegal   = 1'b1;
                    dec.reg_write = 1'b0;
                    dec.ls_enable = 1'b0;
                end
            end
        endcase

        dec.branch_offset = imm[19:0];
    end

    // ------------------------------------------------------------------
    // Queue control
    // ------------------------------------------------------------------
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;
    bundle_t       mem [DEPTH];

    // No push-through when full: a same-cycle pop does not free a slot.
    assign input_ready_o  = (count < CW'(DEPTH)) && !stall_request_i && !flush_i;
    assign output_valid_o = (count != '0);
    assign push           = input_valid_i && input_ready_o;
    assign pop            = output_valid_o && output_ready_i;
    assign count_o        = count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            // Flush wins over any pop presented in the same cycle.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observable while counted.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= dec;
        end
    end

    // ------------------------------------------------------------------
    // Head outputs, forced to a bubble while the queue is empty
    // ------------------------------------------------------------------
    bundle_t head;

    always_comb begin
        head             = '0;
        head.alu_op      = ALU_ADD;
        head.branch_cond = NO_BRANCH;
        if (output_valid_o) begin
            head = mem[rd_ptr];
        end
    end

    assign pc_o               = head.pc;
    assign alu_operand1_o     = head.alu_operand1;
    assign alu_operand2_o     = head.alu_operand2;
    assign alu_op_o           = head.alu_op;
    assign alu_sub_o          = head.alu_sub;
    assign alu_shift_left_o   = head.alu_shift_left;
    assign alu_signed_shift_o = head.alu_signed_shift;
    assign branch_cond_o      = head.branch_cond;
    assign branch_offset_o    = head.branch_offset;
    assign reg_write_o        = head.reg_write;
    assign reg_addr_o         = head.reg_addr;
    assign ls_enable_o        = head.ls_enable;
    assign ls_write_o         = head.ls_write;
    assign ls_write_data_o    = head.ls_write_data;
    assign ls_sel_o           = head.ls_sel;
    assign ls_unsigned_load_o = head.ls_unsigned_load;
    assign illegal_o          = ILLEGAL_CHECK ? head.illegal : 1'b0;

endmodule

// File: tb/tb_decode_queue.sv
// Purpose : checks decode_queue (DEPTH=2 with illegal check, DEPTH=4 without) against a queue model.
// Latency : outputs sampled one time unit after the falling edge, inputs driven on the falling edge.
// Backpressure: the model predicts input_ready_o from its own occupancy, stall and flush.

module tb_decode_queue;

    localparam logic [2:0] NO_BRANCH = 3'd2;
    localparam logic [2:0] UNCOND    = 3'd3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  aop;
        logic        sub;
        logic        sl;
        logic        ss;
        logic [2:0]  bc;
        logic [19:0] bo;
        logic        rw;
        logic [4:0]  rd;
        logic        lse;
        logic        lsw;
        logic [31:0] wd;
        logic [3:0]  sel;
        logic        uns;
        logic        ill;
    } hd_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        input_valid_i = 1'b0;
    logic [31:0] instr_i = '0;
    logic [31:0] pc_i = '0;
    logic        stall_request_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        output_ready_i = 1'b0;
    logic [31:0] rdata1, rdata2;
    logic [31:0] regs [32];

    always #5 clk_i = ~clk_i;

    // DUT A outputs
    logic a_ir, a_ov, a_sub, a_sl, a_ss, a_rw, a_lse, a_lsw, a_uns, a_ill;
    logic [4:0]  a_ra1, a_ra2, a_rd;
    logic [31:0] a_pc, a_op1, a_op2, a_wd;
    logic [2:0]  a_aop, a_bc;
    logic [19:0] a_bo;
    logic [3:0]  a_sel;
    logic [1:0]  a_cnt;
    // DUT B outputs
    logic b_ir, b_ov, b_sub, b_sl, b_ss, b_rw, b_lse, b_lsw, b_uns, b_ill;
    logic [4:0]  b_ra1, b_ra2, b_rd;
    logic [31:0] b_pc, b_op1, b_op2, b_wd;
    logic [2:0]  b_aop, b_bc;
    logic [19:0] b_bo;
    logic [3:0]  b_sel;
    logic [2:0]  b_cnt;

    hd_t obs_a, obs_b;
    assign obs_a = {a_pc, a_op1, a_op2, a_aop, a_sub, a_sl, a_ss, a_bc, a_bo, a_rw, a_rd,
                    a_lse, a_lsw, a_wd, a_sel, a_uns, a_ill};
    assign obs_b = {b_pc, b_op1, b_op2, b_aop, b_sub, b_sl, b_ss, b_bc, b_bo, b_rw, b_rd,
                    b_lse, b_lsw, b_wd, b_sel, b_uns, b_ill};

    assign rdata1 = regs[a_ra1];
    assign rdata2 = regs[a_ra2];

    decode_queue #(.DEPTH(2), .ILLEGAL_CHECK(1'b1)) u_dut_a (
        .clk_i(clk_i), .rst_i(rst_i),
        .input_valid_i(input_valid_i), .input_ready_o(a_ir),
        .instr_i(instr_i), .pc_i(pc_i),
        .raddr1_o(a_ra1), .rdata1_i(rdata1), .raddr2_o(a_ra2), .rdata2_i(rdata2),
        .stall_request_i(stall_request_i), .flush_i(flush_i),
        .output_valid_o(a_ov), .output_ready_i(output_ready_i),
        .pc_o(a_pc), .alu_operand1_o(a_op1), .alu_operand2_o(a_op2), .alu_op_o(a_aop),
        .alu_sub_o(a_sub), .alu_shift_left_o(a_sl), .alu_signed_shift_o(a_ss),
        .branch_cond_o(a_bc), .branch_offset_o(a_bo), .reg_write_o(a_rw), .reg_addr_o(a_rd),
        .ls_enable_o(a_lse), .ls_write_o(a_lsw), .ls_write_data_o(a_wd), .ls_sel_o(a_sel),
        .ls_unsigned_load_o(a_uns), .illegal_o(a_ill), .count_o(a_cnt)
    );

    decode_queue #(.DEPTH(4), .ILLEGAL_CHECK(1'b0)) u_dut_b (
        .clk_i(clk_i), .rst_i(rst_i),
        .input_valid_i(input_valid_i), .input_ready_o(b_ir),
        .instr_i(instr_i), .pc_i(pc_i),
        .raddr1_o(b_ra1), .rdata1_i(rdata1), .raddr2_o(b_ra2), .rdata2_i(rdata2),
        .stall_request_i(stall_request_i), .flush_i(flush_i),
        .output_valid_o(b_ov), .output_ready_i(output_ready_i),
        .pc_o(b_pc), .alu_operand1_o(b_op1), .alu_operand2_o(b_op2), .alu_op_o(b_aop),
        .alu_sub_o(b_sub), .alu_shift_left_o(b_sl), .alu_signed_shift_o(b_ss),
        .branch_cond_o(b_bc), .branch_offset_o(b_bo), .reg_write_o(b_rw), .reg_addr_o(b_rd),
        .ls_enable_o(b_lse), .ls_write_o(b_lsw), .ls_write_data_o(b_wd), .ls_sel_o(b_sel),
        .ls_unsigned_load_o(b_uns), .illegal_o(b_ill), .count_o(b_cnt)
    );

    int  n_cmp = 0;
    int  n_bad = 0;
    hd_t qa[$];
    hd_t qb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic hd_t bubble();
        hd_t e = '0;
        e.bc = NO_BRANCH;
        return e;
    endfunction

    // Reference decode, written opcode by opcode straight from the RV32I field layout.
    function automatic hd_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                       input bit chk_ill);
        hd_t         e;
        logic [6:0]  opc = ins[6:0];
        logic [2:0]  f3  = ins[14:12];
        logic [31:0] r1  = regs[ins[19:15]];
        logic [31:0] r2  = regs[ins[24:20]];
        logic [31:0] iI  = {{20{ins[31]}}, ins[31:20]};
        logic [31:0] iS  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        logic [31:0] iB  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        logic [31:0] iU  = {ins[31:12], 12'h000};
        logic [31:0] iJ  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        logic [31:0] im  = 32'd0;
        e     = '0;
        e.pc  = pc;
        e.sl  = (f3 == 3'd1);
        e.ss  = ins[30];
        e.bc  = NO_BRANCH;
        e.rw  = 1'b1;
        e.rd  = ins[11:7];
        e.wd  = r2;
        e.uns = (f3 == 3'd4) || (f3 == 3'd5);
        e.sel = (f3[1:0] == 2'd0) ? 4'h1 : (f3[1:0] == 2'd1) ? 4'h3 :
                (f3[1:0] == 2'd2) ? 4'hF : 4'h0;
        case (opc)
            7'h37: begin im = iU; e.op2 = iU; end
            7'h17: begin im = iU; e.op1 = pc; e.op2 = iU; end
            7'h6F: begin im = iJ; e.op1 = pc; e.op2 = iJ; e.bc = UNCOND; end
            7'h67: begin im = iI; e.op1 = r1; e.op2 = iI; e.bc = UNCOND; end
            7'h63: begin im = iB; e.op1 = r1; e.op2 = r2; e.bc = f3; e.rw = 1'b0; end
            7'h03: begin im = iI; e.op1 = r1; e.op2 = iI; e.lse = 1'b1; end
            7'h23: begin im = iS; e.op1 = r1; e.op2 = iS; e.lse = 1'b1; e.lsw = 1'b1; e.rw = 1'b0; end
            7'h13: begin
                im    = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, ins[24:20]} : iI;
                e.op1 = r1;
                e.op2 = im;
                e.aop = f3;
            end
            7'h33: begin e.op1 = r1; e.op2 = r2; e.aop = f3; e.sub = ins[30]; end
            default: if (chk_ill) begin e.ill = 1'b1; e.rw = 1'b0; end
        endcase
        e.bo = im[19:0];
        return e;
    endfunction

    task automatic check_head(input string p, input hd_t o, input hd_t e);
        chk({p, "_pc"}, o.pc, e.pc);     chk({p, "_op1"}, o.op1, e.op1);
        chk({p, "_op2"}, o.op2, e.op2);  chk({p, "_aop"}, o.aop, e.aop);
        chk({p, "_sub"}, o.sub, e.sub);  chk({p, "_sl"}, o.sl, e.sl);
        chk({p, "_ss"}, o.ss, e.ss);     chk({p, "_bc"}, o.bc, e.bc);
        chk({p, "_bo"}, o.bo, e.bo);     chk({p, "_rw"}, o.rw, e.rw);
        chk({p, "_rd"}, o.rd, e.rd);     chk({p, "_lse"}, o.lse, e.lse);
        chk({p, "_lsw"}, o.lsw, e.lsw);  chk({p, "_wd"}, o.wd, e.wd);
        chk({p, "_sel"}, o.sel, e.sel);  chk({p, "_uns"}, o.uns, e.uns);
        chk({p, "_ill"}, o.ill, e.ill);
    endtask

    // One cycle: drive on the falling edge, check the settled outputs, then advance the model
    // to what the next rising edge must produce.
    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input bit st, input bit fl, input bit ordy);
        bit rdy_a, rdy_b;
        @(negedge clk_i);
        input_valid_i   = v;
        instr_i         = ins;
        pc_i            = pc;
        stall_request_i = st;
        flush_i         = fl;
        output_ready_i  = ordy;
        #1;
        rdy_a = (qa.size() < 2) && !st && !fl;
        rdy_b = (qb.size() < 4) && !st && !fl;
        chk("a_ra1", a_ra1, ins[19:15]);
        chk("a_ra2", a_ra2, ins[24:20]);
        chk("b_ra1", b_ra1, ins[19:15]);
        chk("a_rdy", a_ir, rdy_a);
        chk("b_rdy", b_ir, rdy_b);
        chk("a_vld", a_ov, qa.size() != 0);
        chk("b_vld", b_ov, qb.size() != 0);
        chk("a_cnt", a_cnt, qa.size());
        chk("b_cnt", b_cnt, qb.size());
        check_head("a", obs_a, (qa.size() != 0) ? qa[0] : bubble());
        check_head("b", obs_b, (qb.size() != 0) ? qb[0] : bubble());
        if (fl) begin
            qa.delete();
            qb.delete();
        end else begin
            if (qa.size() != 0 && ordy) void'(qa.pop_front());
            if (qb.size() != 0 && ordy) void'(qb.pop_front());
            if (v && rdy_a) qa.push_back(ref_decode(ins, pc, 1'b1));
            if (v && rdy_b) qb.push_back(ref_decode(ins, pc, 1'b0));
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [9];
        logic [31:0] r;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        r   = $urandom;
        if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 8)];
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;

        // Reset state and single decode: addi x1,x0,5 at 0x100.
        step(1, 32'h00500093, 32'h100, 0, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0, 0);
        chk("addi_vld", a_ov, 1);          chk("addi_op1", a_op1, 0);
        chk("addi_op2", a_op2, 5);         chk("addi_aop", a_aop, 0);
        chk("addi_rw", a_rw, 1);           chk("addi_rd", a_rd, 1);
        chk("addi_pc", a_pc, 32'h100);     chk("addi_cnt", a_cnt, 1);
        step(0, 32'h0, 32'h0, 0, 0, 1);

        // Fill to full, third offer refused, then drain in order.
        step(1, 32'h12345137, 32'h200, 0, 0, 0);
        step(1, 32'h00112423, 32'h204, 0, 0, 0);
        step(1, 32'h00000013, 32'h208, 0, 0, 0);
        chk("full_cnt", a_cnt, 2);         chk("full_rdy", a_ir, 0);
        step(0, 32'h0, 32'h0, 0, 0, 1);
        chk("lui_op2", a_op2, 32'h12345000);
        step(0, 32'h0, 32'h0, 0, 0, 1);
        chk("sw_op2", a_op2, 8);           chk("sw_lse", a_lse, 1);
        chk("sw_lsw", a_lsw, 1);           chk("sw_sel", a_sel, 4'hF);
        chk("sw_rw", a_rw, 0);
        step(0, 32'h0, 32'h0, 0, 1, 0);    // clear the extra entry DUT B accepted

        // Wrap-around: push and pop every cycle.
        for (int i = 0; i < 7; i++) begin
            step(1, rand_instr(), 32'(4 * i), 0, 0, 1);
            chk("wrap_cnt_le1", a_cnt <= 1, 1);
        end
        step(0, 32'h0, 32'h0, 0, 0, 1);

        // Flush with two queued while an instruction is offered.
        step(1, 32'h00500093, 32'h300, 0, 0, 0);
        step(1, 32'h00A00113, 32'h304, 0, 0, 0);
        step(1, 32'h00F00193, 32'h308, 0, 1, 1);
        chk("flush_rdy", a_ir, 0);
        step(0, 32'h0, 32'h0, 0, 0, 0);
        chk("flush_vld", a_ov, 0);         chk("flush_cnt", a_cnt, 0);
        chk("flush_rw", a_rw, 0);          chk("flush_bc", a_bc, NO_BRANCH);

        // Illegal opcode, then stall while the head still pops.
        step(1, 32'h00000000, 32'h400, 0, 0, 0);
        step(1, 32'h00500093, 32'h404, 1, 0, 1);
        chk("ill_flag", a_ill, 1);         chk("ill_rw", a_rw, 0);
        chk("ill_lse", a_lse, 0);          chk("stall_rdy", a_ir, 0);
        chk("ill_nochk", b_ill, 0);
        step(0, 32'h0, 32'h0, 0, 0, 0);
        chk("stall_pop_cnt", a_cnt, 0);

        // Asynchronous reset between clock edges with two entries queued.
        step(1, 32'h12345137, 32'h500, 0, 0, 0);
        step(1, 32'h00112423, 32'h504, 0, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0, 0);
        @(posedge clk_i);
        #2;
        chk("pre_arst_cnt", a_cnt, 2);
        rst_i = 1'b1;
        #1;
        chk("arst_vld", a_ov, 0);          chk("arst_cnt", a_cnt, 0);
        chk("arst_b_cnt", b_cnt, 0);
        check_head("arst_a", obs_a, bubble());
        qa.delete();
        qb.delete();
        @(negedge clk_i);
        rst_i = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, rand_instr(), $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 19) < 3, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 6);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the single-register decode stage.
- Decodes one RV32I instruction per cycle from fetch and pushes the decoded bundle into a DEPTH-entry FIFO that feeds execute.
- Adds behaviour the single-register stage lacks: pipeline flush, illegal-instruction detection, and an occupancy count.
- Sits between fetch and execute. The register file is read combinationally in the push cycle.

Parameters:
- DEPTH, 2, number of FIFO entries; power of two, >= 2.
- ILLEGAL_CHECK, 1, when 1 unknown opcodes set the entry's illegal flag; when 0, illegal_o is tied to 0.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- input_valid_i  in  1  fetch offers instr_i/pc_i.
- input_ready_o  out  1  decode accepts the offer this cycle.
- instr_i  in  32  instruction word.
- pc_i  in  32  instruction address.
- raddr1_o  out  5  = instr_i[19:15], combinational.
- rdata1_i  in  32  register file data for raddr1_o.
- raddr2_o  out  5  = instr_i[24:20], combinational.
- rdata2_i  in  32  register file data for raddr2_o.
- stall_request_i  in  1  hazard unit blocks pushes.
- flush_i  in  1  discards all queued and offered instructions.
- output_valid_o  out  1  head entry valid.
- output_ready_i  in  1  execute consumes the head.
- pc_o  out  32  head field.
- alu_operand1_o  out  32  head field.
- alu_operand2_o  out  32  head field.
- alu_op_o  out  3  head field.
- alu_sub_o  out  1  head field.
- alu_shift_left_o  out  1  head field.
- alu_signed_shift_o  out  1  head field.
- branch_cond_o  out  3  head field.
- branch_offset_o  out  20  head field.
- reg_write_o  out  1  head field.
- reg_addr_o  out  5  head field.
- ls_enable_o  out  1  head field.
- ls_write_o  out  1  head field.
- ls_write_data_o  out  32  head field.
- ls_sel_o  out  4  head field.
- ls_unsigned_load_o  out  1  head field.
- illegal_o  out  1  head instruction has an unknown opcode.
- count_o  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Decode rules, bundle fields:
  - Immediates: I/S/B/U/J per the RV32I spec. Shift-immediates (OP_IMM with SLL or SRL) are zero-extended instr_i[24:20].
  - operand1: pc for AUIPC/JAL; rdata1 for JALR/BRANCH/OP/OP_IMM/LOAD/STORE; else 0.
  - operand2: immediate for LUI/AUIPC/JAL/JALR/OP_IMM/LOAD/STORE; rdata2 for BRANCH/OP; else 0.
  - alu_op: func3-mapped for OP/OP_IMM; else ALU_ADD.
  - alu_sub = OP && instr[30]; alu_signed_shift = instr[30]; alu_shift_left = (func3 == SLL).
  - branch_cond: func3-mapped for BRANCH; BRANCH_UNCOND for JAL/JALR; else NO_BRANCH.
  - branch_offset = immediate[19:0].
  - reg_write = not STORE/BRANCH; reg_addr = rd.
  - ls_enable = LOAD or STORE; ls_write = STORE; ls_write_data = rdata2.
  - ls_sel: func3[1:0] 00→0001, 01→0011, 10→1111, 11→0000.
  - ls_unsigned_load = func3 is LBU or LHU.
- Illegal: opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP, OP_IMM} and ILLEGAL_CHECK=1. For an illegal entry: illegal=1, reg_write=0, ls_enable=0, branch_cond=NO_BRANCH.
- Handshake:
  - input_ready_o = (count < DEPTH) && !stall_request_i && !flush_i. There is no push-through-full, even when a pop occurs in the same cycle.
  - push = input_valid_i && input_ready_o.
  - pop = output_valid_o && output_ready_i.
  - output_valid_o = (count != 0).
- Latency: an instruction accepted at edge N is visible on outputs after edge N, provided the queue was empty and no flush occurred. There is no combinational path from instr_i to the head outputs.
- FIFO:
  - Write pointer and read pointer are log2(DEPTH) bits and wrap modulo DEPTH.
  - count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Strict FIFO order.
- Flush:
  - Highest priority. On the edge where flush_i=1: count←0, both pointers←0, any pop is discarded.
  - No push is possible during flush because input_ready_o=0.
- Stall: blocks pushes only; pops continue.
- Empty outputs: when output_valid_o=0 every head field reads as a bubble: all zero, alu_op=ALU_ADD, branch_cond=NO_BRANCH, illegal=0.
- Reset (async, any time, including mid-operation): count_o=0, pointers=0, output_valid_o=0, all head fields at bubble values. Storage contents are don't-care. input_ready_o=1 once rst_i deasserts, provided stall_request_i=0 and flush_i=0.

Test Plan:
- Single decode: reset; push addi x1,x0,5 (0x00500093) at pc 0x100 with rdata1=0 → next cycle output_valid_o=1, alu_operand1_o=0, alu_operand2_o=5, alu_op_o=ALU_ADD, reg_write_o=1, reg_addr_o=1, pc_o=0x100, count_o=1.
- Fill/full, DEPTH=2, output_ready_i=0: push lui x2,0x12345 (0x12345137) then sw x1,8(x2) (0x00112423) → count_o=2, input_ready_o=0. The third offer is not accepted. Pop twice → order lui (operand2=0x12345000), then sw (operand2=8, ls_enable=1, ls_write=1, ls_sel=1111, reg_write=0).
- Wrap-around: 7 consecutive push+pop cycles, pcs 0x0,0x4,…,0x18 → outputs in order, count_o stays ≤1, no loss or duplication.
- Flush with 2 queued while pushing → next cycle count_o=0, output_valid_o=0, reg_write_o=0, branch_cond_o=NO_BRANCH. The offered instruction is not consumed.
- Illegal/stall: push 0x00000000 → illegal_o=1, reg_write_o=0, ls_enable_o=0. Assert stall_request_i → input_ready_o=0 while the head still pops on output_ready_i. Repeat with ILLEGAL_CHECK=0 → illegal_o=0.
- Async reset mid-operation: assert rst_i with count=2 between clock edges → output_valid_o=0 and count_o=0 immediately, without waiting for a clock edge.
